conv_enc_tb_param: RTL and testbench

- Parametrised tail-biting convolutional encoder core. Successor to the fixed rate-1/3, K=7 encoder that sits between the data/meta ingress FIFOs and the sub-block FIFOs.
- Pops one meta byte and then one block of data bytes from the ingress FIFOs, and buffers the block internally so the tail-biting initial state is known before encoding.
- Encodes byte-parallel (8 bits/cycle) into NUM_OUT streams and writes one byte per stream per cycle downstream.

---
 rtl/conv_enc_tb_param.sv | 163 ++++++++++++++++
 tb/tb_conv_enc_tb_param.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_enc_tb_param.sv
// Tail-biting convolutional encoder (rate 1/NUM_OUT, byte-parallel) with an internal block buffer.
// Build option CONV_ENC_ZT_EN: meta[1]=1 starts the block from the all-zero state instead.
module conv_enc_tb_param #(
  parameter int                   K           = 7,
  parameter int                   NUM_OUT     = 3,
  parameter logic [NUM_OUT*K-1:0] G           = {7'o133, 7'o171, 7'o165},
  parameter int                   SMALL_BYTES = 132,
  parameter int                   LARGE_BYTES = 768,
  parameter int                   AW          = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_empty_meta,
  input  logic [7:0]           in_meta,
  output logic                 in_rdreq_meta,
  input  logic                 in_empty_data,
  input  logic [7:0]           in_data,
  output logic                 in_rdreq_data,
  input  logic                 out_full,
  output logic [NUM_OUT*8-1:0] out_data,
  output logic                 out_wrreq,
  output logic                 busy,
  output logic                 blk_done,
  output logic [AW-1:0]        byte_count
);

  localparam int            CW    = AW + 1;
  localparam logic [CW-1:0] LEN_S = CW'(SMALL_BYTES);
  localparam logic [CW-1:0] LEN_L = CW'(LARGE_BYTES);

  typedef enum logic [2:0] {IDLE, META, LOAD, ENC, DONE} state_t;

  state_t              state_reg;
  logic [CW-1:0]       len_reg;
  logic [CW-1:0]       rd_cnt_reg;
  logic [CW-1:0]       cnt_reg;
  logic                dv_reg;
  logic                fin_reg;
  logic [K-2:0]        sr_reg;   // sr_reg[K-2-i] holds s[i], so the window is {u, sr_reg}
  logic [7:0]          mem [0:(2**AW)-1];
  logic [7:0]          buf_q;
  logic                ram_we;
  logic                rd_en;
  logic [K-2:0]        tb_init;
  logic [K-2:0]        start_sr;
  logic [NUM_OUT*8-1:0] enc_out;
  logic [K-2:0]        enc_sr;
  logic [K-1:0]        enc_w;
  logic                meta_unused;

  assign meta_unused   = ^in_meta[7:1];
  assign busy          = (state_reg != IDLE);
  assign byte_count    = cnt_reg[AW-1:0];
  assign in_rdreq_meta = !reset && (state_reg == IDLE) && !in_empty_meta;
  assign in_rdreq_data = !reset && (state_reg == LOAD) && !in_empty_data && (rd_cnt_reg < len_reg);
  assign rd_en         = (state_reg == ENC) && !out_full && (rd_cnt_reg < len_reg);
  assign ram_we        = (state_reg == LOAD) && dv_reg;

  // Tail-biting start: the last K-1 input bits, s[i] = last_byte[i].
  for (genvar gi = 0; gi < K-1; gi++) begin : g_init
    assign tb_init[K-2-gi] = in_data[gi];
  end

`ifdef CONV_ENC_ZT_EN
  logic zt_reg;
  assign start_sr = zt_reg ? '0 : tb_init;
`else
  assign start_sr = tb_init;
`endif

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[cnt_reg[AW-1:0]] <= in_data;
    end
    if (rd_en) begin
      buf_q <= mem[rd_cnt_reg[AW-1:0]];
    end
  end

  // Eight encoder steps per cycle, bit7 first; stream 0 takes the leftmost generator.
  always_comb begin
    enc_out = '0;
    enc_sr  = sr_reg;
    enc_w   = '0;
    for (int t = 7; t >= 0; t--) begin
      enc_w = {buf_q[t], enc_sr};
      for (int j = 0; j < NUM_OUT; j++) begin
        enc_out[j*8 + t] = ^(enc_w & G[(NUM_OUT-1-j)*K +: K]);
      end
      enc_sr = enc_w[K-1:1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      len_reg    <= '0;
      rd_cnt_reg <= '0;
      cnt_reg    <= '0;
      dv_reg     <= 1'b0;
      fin_reg    <= 1'b0;
      sr_reg     <= '0;
      out_data   <= '0;
      out_wrreq  <= 1'b0;
      blk_done   <= 1'b0;
`ifdef CONV_ENC_ZT_EN
      zt_reg     <= 1'b0;
`endif
    end else begin
      out_wrreq <= 1'b0;
      blk_done  <= 1'b0;
      dv_reg    <= in_rdreq_data | rd_en;
      case (state_reg)
        IDLE: begin
          if (in_rdreq_meta) state_reg <= META;
        end
        META: begin
          len_reg    <= in_meta[0] ? LEN_L : LEN_S;
`ifdef CONV_ENC_ZT_EN
          zt_reg     <= in_meta[1];
`endif
          rd_cnt_reg <= '0;
          cnt_reg    <= '0;
          fin_reg    <= 1'b0;
          state_reg  <= LOAD;
        end
        LOAD: begin
          if (in_rdreq_data) rd_cnt_reg <= rd_cnt_reg + CW'(1);
          if (dv_reg) begin
            if (cnt_reg == len_reg - CW'(1)) begin
              sr_reg     <= start_sr;
              cnt_reg    <= '0;
              rd_cnt_reg <= '0;
              state_reg  <= ENC;
            end else begin
              cnt_reg <= cnt_reg + CW'(1);
            end
          end
        end
        ENC: begin
          if (rd_en) rd_cnt_reg <= rd_cnt_reg + CW'(1);
          if (dv_reg) begin
            out_data  <= enc_out;
            out_wrreq <= 1'b1;
            sr_reg    <= enc_sr;
            cnt_reg   <= cnt_reg + CW'(1);
            if (cnt_reg == len_reg - CW'(1)) fin_reg <= 1'b1;
          end
          // fin_reg is seen while the last write strobe is on the port
          if (fin_reg) begin
            blk_done  <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_enc_tb_param.sv
// Randomized bench for conv_enc_tb_param against a bit-serial convolution model.
// Honours CONV_ENC_ZT_EN the same way the design does.
module tb_conv_enc_tb_param;
  localparam int K = 7;
  localparam int NUM_OUT = 3;
  localparam int AW = 10;
  localparam int SMALL = 132;
  localparam int LARGE = 768;
`ifdef CONV_ENC_ZT_EN
  localparam bit ZT_BUILD = 1'b1;
`else
  localparam bit ZT_BUILD = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 in_empty_meta = 1'b1;
  logic [7:0]           in_meta = '0;
  logic                 in_rdreq_meta;
  logic                 in_empty_data = 1'b1;
  logic [7:0]           in_data = '0;
  logic                 in_rdreq_data;
  logic                 out_full = 1'b0;
  logic [NUM_OUT*8-1:0] out_data;
  logic                 out_wrreq;
  logic                 busy;
  logic                 blk_done;
  logic [AW-1:0]        byte_count;

  conv_enc_tb_param #(.K(K), .NUM_OUT(NUM_OUT), .SMALL_BYTES(SMALL), .LARGE_BYTES(LARGE), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_empty_meta(in_empty_meta), .in_meta(in_meta), .in_rdreq_meta(in_rdreq_meta),
    .in_empty_data(in_empty_data), .in_data(in_data), .in_rdreq_data(in_rdreq_data),
    .out_full(out_full), .out_data(out_data), .out_wrreq(out_wrreq),
    .busy(busy), .blk_done(blk_done), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int gens [NUM_OUT] = '{'o133, 'o171, 'o165};

  logic [7:0]  meta_q[$];
  logic [7:0]  data_q[$];
  logic [7:0]  blk[$];
  logic [23:0] exp_q[$];

  bit pop_meta = 0, pop_data = 0;
  bit data_jitter = 0, full_jitter = 0, full_force = 0;
  int wr_cnt = 0, rd_cnt = 0, cur_len = 0, done_cnt = 0, done_start = 0;
  bit prev_wrreq = 0, prev_done = 0;
  logic [23:0] first_out = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each output bit is the mod-2 convolution of the bit stream with the generator;
  // bits before the block start wrap to the block tail (tail-biting) or are zero.
  task automatic model_block(input logic [7:0] meta);
    int n;
    int nb;
    bit zt;
    bit bits[];
    n  = blk.size();
    nb = n * 8;
    zt = ZT_BUILD && meta[1];
    bits = new[nb];
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) bits[i*8+k] = blk[i][7-k];
    for (int i = 0; i < n; i++) begin
      logic [23:0] word;
      word = '0;
      for (int k = 0; k < 8; k++) begin
        for (int j = 0; j < NUM_OUT; j++) begin
          bit acc;
          acc = 0;
          for (int d = 0; d < K; d++) begin
            int p;
            bit x;
            p = i*8 + k - d;
            if (p >= 0) x = bits[p];
            else x = zt ? 1'b0 : bits[p + nb];
            acc ^= x & gens[j][K-1-d];
          end
          word[j*8 + 7 - k] = acc;
        end
      end
      exp_q.push_back(word);
    end
  endtask

  // Input FIFOs: q updates just after the edge that consumed the read request.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (pop_meta && meta_q.size() > 0) in_meta = meta_q.pop_front();
      if (pop_data && data_q.size() > 0) in_data = data_q.pop_front();
    end
    pop_meta = 0;
    pop_data = 0;
    in_empty_meta = (meta_q.size() == 0);
    in_empty_data = (data_q.size() == 0) || (data_jitter && $urandom_range(0, 2) == 0);
    out_full = full_force || (full_jitter && $urandom_range(0, 3) == 0);
  end

  always @(negedge clk) begin
    if (!reset) begin
      pop_meta = in_rdreq_meta;
      pop_data = in_rdreq_data;
      if (in_empty_meta) check("rdreq_meta_when_empty", in_rdreq_meta, 0);
      if (in_empty_data) check("rdreq_data_when_empty", in_rdreq_data, 0);
      if (in_rdreq_data) rd_cnt++;
      if (out_wrreq) begin
        if (wr_cnt == 0) first_out = out_data;
        wr_cnt++;
        if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
        else check("extra_write", out_wrreq, 0);
      end
      if (prev_done) begin
        check("done_pulse_width", blk_done, 0);
        check("busy_after_done", busy, 0);
      end
      if (blk_done) begin
        check("done_after_last_wr", prev_wrreq, 1);
        check("wr_count_at_done", wr_cnt, cur_len);
        done_cnt++;
      end
      prev_wrreq = out_wrreq;
      prev_done  = blk_done;
    end
  end

  task automatic start_block(input logic [7:0] meta);
    exp_q.delete();
    model_block(meta);
    wr_cnt = 0;
    rd_cnt = 0;
    cur_len = blk.size();
    done_start = done_cnt;
    foreach (blk[i]) data_q.push_back(blk[i]);
    meta_q.push_back(meta);
  endtask

  task automatic finish_block(input string name);
    for (int c = 0; c < 20000 && done_cnt == done_start; c++) @(negedge clk);
    check("block_done_seen", done_cnt != done_start, 1);
    check("rd_count", rd_cnt, cur_len);
    check("wr_count", wr_cnt, cur_len);
    check("exp_left", exp_q.size(), 0);
    $display("block %s len=%0d reads=%0d writes=%0d", name, cur_len, rd_cnt, wr_cnt);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic fill_blk(input int n, input int mode);
    blk.delete();
    for (int i = 0; i < n; i++) begin
      if (mode == 0) blk.push_back(8'h00);
      else blk.push_back(8'($urandom_range(0, 255)));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_out_wrreq", out_wrreq, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_blk_done", blk_done, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_rdreq_meta", in_rdreq_meta, 0);
    check("rst_rdreq_data", in_rdreq_data, 0);
    reset = 1'b0;
    @(negedge clk);

    // all-zero small block
    fill_blk(SMALL, 0);
    start_block(8'h00);
    finish_block("zero");

    // last byte 0x01 sets s[0]=1 for the first step
    fill_blk(SMALL, 0);
    blk[SMALL-1] = 8'h01;
    start_block(8'h00);
    finish_block("tb_init");
    check("tb_first_bit_s0", first_out[7], 0);
    check("tb_first_bit_s1", first_out[15], 1);
    check("tb_first_bit_s2", first_out[23], 1);

    // large random block with jittery input and output flow control
    fill_blk(LARGE, 1);
    data_jitter = 1;
    full_jitter = 1;
    start_block({6'($urandom_range(0, 63)), 2'b01});
    finish_block("large_rand");
    data_jitter = 0;
    full_jitter = 0;

    // out_full held for 10 cycles in the middle of ENC
    fill_blk(SMALL, 1);
    start_block(8'h00);
    for (int c = 0; c < 5000 && wr_cnt < 40; c++) @(negedge clk);
    check("stall_reach_40", wr_cnt >= 40, 1);
    full_force = 1;
    for (int c = 0; c < 5 && !out_full; c++) @(negedge clk);
    check("stall_full_seen", out_full, 1);
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) check("stall_no_wr", out_wrreq, 0);
      @(negedge clk);
    end
    full_force = 0;
    finish_block("stall");

    // reset in the middle of LOAD
    fill_blk(SMALL, 1);
    start_block(8'h01);
    for (int c = 0; c < 5000 && !(busy && byte_count == 10'd50); c++) @(negedge clk);
    check("reach_byte50", byte_count, 50);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_out_wrreq", out_wrreq, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_blk_done", blk_done, 0);
    check("mid_rst_byte_count", byte_count, 0);
    check("mid_rst_rdreq_meta", in_rdreq_meta, 0);
    check("mid_rst_rdreq_data", in_rdreq_data, 0);
    meta_q.delete();
    data_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    prev_wrreq = 0;
    prev_done = 0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    fill_blk(SMALL, 1);
    start_block(8'h00);
    finish_block("after_reset");

    // meta[1] selects zero-state start only when the option is built in
    fill_blk(SMALL, 0);
    blk[SMALL-1] = 8'h01;
    start_block(8'h02);
    finish_block("zt_select");
    check("zt_first_bit_s0", first_out[7], 0);
    check("zt_first_bit_s1", first_out[15], ZT_BUILD ? 0 : 1);
    check("zt_first_bit_s2", first_out[23], ZT_BUILD ? 0 : 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
